// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
//
// Standalone UART transmitter. Sends 8-bit frames on txd:
//   start bit (0), 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
// A one-byte holding register sits in front of the shift register. This lets
// the host queue the next byte while the current one is shifting, so
// back-to-back frames leave with no idle gap. The bit period is picked per
// frame from br_cfg, using the same 2-bit encoding as the receive path.
// br_cfg is sampled only when a frame is loaded.
//
// Parameters:
//   DIV_00..DIV_11 : clock cycles per bit for br_cfg = 00..11. Each must be >= 2.
//   PARITY         : 0 = none, 1 = even, 2 = odd
//   STOP_BITS      : 1 or 2
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   br_cfg     in   [1:0] baud select, sampled at frame start
//   tx_data    in   [7:0] byte to send
//   tx_valid   in   tx_data valid
//   tx_ready   out  holding register empty; a byte is taken when
//                   tx_valid && tx_ready at a rising edge
//   txd        out  serial line, idle high, registered
//   tx_busy    out  transmitter FSM not in IDLE
//   frame_done out  one-cycle pulse during the last cycle of the final stop bit
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int DIV_00    = 1300,
    parameter int DIV_01    = 650,
    parameter int DIV_10    = 325,
    parameter int DIV_11    = 163,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       tx_busy,
    output logic       frame_done
);

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t             state;
    logic               hold_full;
    logic [7:0]         hold_data;
    logic [7:0]         shift;
    logic               par_bit;
    logic [CNT_W-1:0]   div_r;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         bit_idx;
    logic               stop_idx;

    logic               accept;
    logic               bit_end;
    logic               last_stop;
    logic               load;

    // Bit period for a given baud select code.
    function automatic logic [CNT_W-1:0] sel_div(input logic [1:0] cfg);
        logic [CNT_W-1:0] d;
        case (cfg)
            2'b00:   d = CNT_W'(DIV_00);
            2'b01:   d = CNT_W'(DIV_01);
            2'b10:   d = CNT_W'(DIV_10);
            default: d = CNT_W'(DIV_11);
        endcase
        return d;
    endfunction

    // Parity bit for a data byte. Even parity is the XOR of the data bits.
    // Odd parity is its inverse. The result is unused when PARITY == 0.
    function automatic logic frame_parity(input logic [7:0] d);
        return (^d) ^ (PARITY == 2);
    endfunction

    // tx_ready comes only from the holding-register flag. It never depends
    // combinationally on tx_valid.
    assign tx_ready  = ~hold_full;
    assign accept    = tx_valid & ~hold_full;
    assign bit_end   = (cnt == div_r - CNT_W'(1));
    assign last_stop = (STOP_BITS == 2) ? stop_idx : 1'b1;

    // The shift register is loaded from IDLE, or straight out of the final
    // stop bit when another byte is waiting. The second case is what makes
    // consecutive frames touch with no gap.
    assign load = hold_full &
                  ((state == ST_IDLE) |
                   ((state == ST_STOP) & bit_end & last_stop));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            hold_full  <= 1'b0;
            hold_data  <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            div_r      <= '0;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            txd        <= 1'b1;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // Holding register. A load empties it. Because tx_ready was low
            // on a load edge, a byte offered on that edge is not taken until
            // the following edge.
            if (load) begin
                hold_full <= 1'b0;
            end else if (accept) begin
                hold_full <= 1'b1;
                hold_data <= tx_data;
            end

            if (load) begin
                shift    <= hold_data;
                par_bit  <= frame_parity(hold_data);
                div_r    <= sel_div(br_cfg);
                cnt      <= '0;
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                txd      <= 1'b0;
                tx_busy  <= 1'b1;
                state    <= ST_START;
            end else begin
                case (state)
                    ST_IDLE: begin
                        txd     <= 1'b1;
                        tx_busy <= 1'b0;
                    end

                    ST_START: begin
                        if (bit_end) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            txd     <= shift[0];
                            state   <= ST_DATA;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    ST_DATA: begin
                        if (bit_end) begin
                            cnt   <= '0;
                            shift <= {1'b0, shift[7:1]};
                            if (bit_idx == 3'd7) begin
                                if (PARITY != 0) begin
                                    txd   <= par_bit;
                                    state <= ST_PARITY;
                                end else begin
                                    txd   <= 1'b1;
                                    state <= ST_STOP;
                                end
                            end else begin
                                // Present the next data bit on the same edge as the shift.
                                txd     <= shift[1];
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    ST_PARITY: begin
                        if (bit_end) begin
                            cnt   <= '0;
                            txd   <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    ST_STOP: begin
                        txd <= 1'b1;
                        if (bit_end) begin
                            cnt <= '0;
                            if (last_stop) begin
                                // When hold_full is set, load already took this edge.
                                tx_busy <= 1'b0;
                                state   <= ST_IDLE;
                            end else begin
                                stop_idx <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                            // frame_done is registered, so it is raised one
                            // cycle early. It is then high exactly during the
                            // final cycle of the stop period.
                            if (last_stop && (cnt == div_r - CNT_W'(2)))
                                frame_done <= 1'b1;
                        end
                    end

                    default: begin
                        txd     <= 1'b1;
                        tx_busy <= 1'b0;
                        state   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
